serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial add/subtract controller that time-shares a single 1-bit full-adder cell across a WIDTH-bit operand pair. On a start edge it latches switch operands and steps the cell one bit per clock. It assembles the WIDTH+1-bit result and holds it for the hex display path. It also flags completion with a one-cycle pulse. The block sits between the switch/button inputs and the display driver, replacing a purely combinational adder.

## Interface
- WIDTH, 8: operand width in bits; legal range 1..16.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level request, typically from a button. Only a rising edge requests an operation.
- sub  input  1  0 = A+B, 1 = A−B. Sampled together with the operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- result  output  WIDTH+1  final result; bit WIDTH is the carry-out.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result has just been updated.

## Operation
- Reset values:
  - State is IDLE.
  - result, busy, done, the operand shift registers, carry, bit counter and partial-sum register are all 0.
  - start_q (previous start) resets to 1, so a start held high through reset release does not trigger an operation.
- Start edge = start & ~start_q, evaluated every cycle. start_q <= start every cycle.
- IDLE:
  - On a start edge:
    - a_sr <= a.
    - b_sr <= sub ? ~b : b.
    - carry <= sub.
    - cnt <= 0.
    - Go to RUN.
  - Otherwise stay in IDLE.
- RUN (busy=1), each cycle:
  - The cell computes s, co from a_sr[0], b_sr[0], carry.
  - ps <= {s, ps[WIDTH-1:1]}.
  - a_sr and b_sr shift right by 1.
  - carry <= co.
  - cnt <= cnt+1.
  - When cnt == WIDTH-1:
    - result <= {co, s, ps[WIDTH-1:1]}.
    - Go to DONE.
- DONE (busy=0, done=1): go to IDLE unconditionally.
- While in RUN or DONE:
  - Start edges are ignored and are not queued.
  - Changes on a, b or sub have no effect.
- result holds its value until the next operation completes. It never shows partial sums.
- Subtract semantics: result[WIDTH]=1 means no borrow (A ≥ B). The low WIDTH bits are A−B mod 2^WIDTH.
- Reset asserted in any state overrides everything. It returns all state to reset values on that edge and aborts any operation in flight.
- busy and done are never high in the same cycle.

## Timing
- The start edge is sampled at edge T. busy is high from T+1 through T+WIDTH, i.e. WIDTH cycles.
- result updates and done is high in cycle T+WIDTH+1. The block is back in IDLE at T+WIDTH+2.
- A new start edge is accepted in the DONE cycle's successor (IDLE) at the earliest. The minimum operation period is WIDTH+2 cycles.
- Counter width is $clog2(WIDTH). For WIDTH=1, RUN lasts exactly one cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- A shared package holds:
  - the state enum (IDLE, RUN, DONE);
  - a MAX_WIDTH=16 constant, checked by an elaboration-time assertion on WIDTH.
- One sub-module, full_adder_cell (a, b, cin -> sum, cout), purely combinational. It is instantiated once.
- The top level wires result to HexDisplayV2's value_in, zero-extended to 16 bits, and start to btnC.

## Test plan
- WIDTH=8, add, a=0x5A, b=0x3C, start edge at T:
  - busy is high for 8 cycles.
  - At T+9: result=0x096, done=1 for one cycle.
  - At T+10: IDLE.
- Add 0xFF+0x01 -> result=0x100. Add 0x00+0x00 -> result=0x000 with done still pulsed.
- Subtract 0x10−0x01 -> result=0x10F. Subtract 0x01−0x02 -> result=0x0FF (borrow).
- During RUN, toggle start again and change a/b/sub:
  - The result is still computed from the latched operands.
  - No second operation follows.
  - Exactly one done pulse occurs.
- Assert reset at cnt=3 of an operation whose prior result was 0x096:
  - Next cycle, result=0, busy=0, done=0, state IDLE.
  - Start held high across reset release causes no operation; a fresh low->high edge does.
- WIDTH=1 instance: a=1, b=1, add -> busy for 1 cycle, result=2'b10.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg
//   Shared definitions for the bit-serial add/subtract controller:
//   the controller state encoding and the widest operand it supports.
package serial_adder_ctrl_pkg;

  localparam int MAX_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_full_adder_cell.sv
// full_adder_cell
//   Single 1-bit full adder, purely combinational. The serial controller
//   time-shares one of these across all operand bits.
//   a, b, cin : addend bits and carry-in
//   sum, cout : sum bit and carry-out
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial A+B / A-B controller. A rising edge on start latches the
//   operands, then one full-adder cell is stepped LSB first, one bit per
//   clock. The WIDTH+1-bit result (carry-out on top) is loaded in one go
//   when the last bit is done, and done pulses for one cycle.
//   clk, reset   : clock, synchronous active-high reset
//   start        : level request; only its rising edge starts an operation
//   sub          : 0 = add, 1 = subtract (sampled with a/b)
//   a, b         : operands
//   result       : registered result, bit WIDTH = carry-out (1 = no borrow)
//   busy, done   : registered status; busy during RUN, done during DONE
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for a start edge; result holds the last answer
//   RUN   | one operand bit per cycle through the full-adder cell
//   DONE  | result just loaded, done pulse; back to IDLE next cycle
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   result,
  output logic             busy,
  output logic             done
);

  generate
    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("serial_adder_ctrl: WIDTH must be in 1..MAX_WIDTH");
    end
  endgenerate

  // A 1-bit counter is still needed when WIDTH=1, where $clog2 gives 0.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_d;
  logic             start_q;
  logic             start_edge;
  logic [WIDTH-1:0] a_sr, b_sr, ps;
  logic [WIDTH-1:0] next_ps;
  logic             ps_unused;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             s, co;

  full_adder_cell u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (s),
    .cout (co)
  );

  assign start_edge = start & ~start_q;

  // New sum bit enters at the top; the bit falling out of ps is discarded.
  assign {next_ps, ps_unused} = {s, ps};

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start_edge) state_d = RUN;
      RUN:     if (cnt == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // start_q resets high so a button held through reset is not an edge.
      start_q <= 1'b1;
      a_sr    <= '0;
      b_sr    <= '0;
      ps      <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      start_q <= start;
      busy    <= (state_d == RUN);
      done    <= (state_d == DONE);
      case (state)
        IDLE: begin
          if (start_edge) begin
            // Subtract as A + ~B + 1: invert B and seed the carry.
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          ps    <= next_ps;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= co;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) result <= {co, next_ps};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
//   Randomized scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
//   Expected results come from plain integer arithmetic and are queued when
//   an operation is issued; a monitor pops and compares on every done pulse.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start8, sub8;
  logic [7:0] a8, b8;
  logic [8:0] result8;
  logic       busy8, done8;
  logic       start1, sub1;
  logic [0:0] a1, b1;
  logic [1:0] result1;
  logic       busy1, done1;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .result(result8), .busy(busy8), .done(done8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .result(result1), .busy(busy1), .done(done1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int overlap  = 0;
  int partial  = 0;
  logic [16:0] q8[$];
  logic [16:0] q1[$];
  logic [8:0]  prev8;
  logic [1:0]  prev1;
  logic        rst_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: add is plain a+b; subtract is (a-b) mod 2^w with the top bit
  // set when no borrow occurs (a >= b).
  function automatic logic [16:0] ref_calc(input int w, input int av, input int bv, input bit sv);
    int mask;
    int r;
    mask = (1 << w) - 1;
    if (sv) r = ((av - bv) & mask) | ((av >= bv) ? (1 << w) : 0);
    else    r = av + bv;
    return 17'(r);
  endfunction

  always @(posedge clk) rst_q <= reset;

  always @(negedge clk) begin
    logic [16:0] e;
    if (busy8 && done8) overlap++;
    if (busy1 && done1) overlap++;
    if (done8) begin
      if (q8.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done8: no operation pending, result=0x%0h", result8);
      end else begin
        e = q8.pop_front();
        check("result8", {23'd0, result8}, {23'd0, e[8:0]});
      end
    end
    if (done1) begin
      if (q1.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done1: no operation pending, result=0x%0h", result1);
      end else begin
        e = q1.pop_front();
        check("result1", {30'd0, result1}, {30'd0, e[1:0]});
      end
    end
    if (rst_q === 1'b0 && !done8 && result8 !== prev8) partial++;
    if (rst_q === 1'b0 && !done1 && result1 !== prev1) partial++;
    prev8 = result8;
    prev1 = result1;
  end

  task automatic run_op(input bit is1, input int av, input int bv, input bit sv, input bit scramble);
    int w;
    int bcnt;
    int lat;
    logic bz, dn;
    w = is1 ? 1 : 8;
    bcnt = 0;
    lat = 0;
    @(negedge clk);
    if (is1) start1 = 1'b0; else start8 = 1'b0;
    @(negedge clk);
    if (is1) begin a1 = av[0:0]; b1 = bv[0:0]; sub1 = sv; start1 = 1'b1; q1.push_back(ref_calc(1, av, bv, sv)); end
    else     begin a8 = av[7:0]; b8 = bv[7:0]; sub8 = sv; start8 = 1'b1; q8.push_back(ref_calc(8, av, bv, sv)); end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      bz = is1 ? busy1 : busy8;
      dn = is1 ? done1 : done8;
      if (bz) bcnt++;
      if (dn) begin lat = i; break; end
      if (scramble && bz) begin
        if (is1) begin start1 = ~start1; a1 = 1'($urandom); b1 = 1'($urandom); sub1 = 1'($urandom); end
        else     begin start8 = ~start8; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); end
      end
    end
    if (lat == 0) begin
      n_checks++;
      $display("FAIL done_timeout: no done within 40 cycles, width=%0d a=0x%0h b=0x%0h", w, av, bv);
    end else begin
      check("done_latency", lat, w + 1);
      check("busy_cycles", bcnt, w);
    end
    @(negedge clk);
    check("idle_after_done", is1 ? {busy1, done1} : {busy8, done8}, 0);
    if (is1) start1 = 1'b0; else start8 = 1'b0;
  endtask

  initial begin
    int idle_busy;
    reset = 1'b1;
    start8 = 1'b1; sub8 = 1'b0; a8 = '0; b8 = '0;
    start1 = 1'b1; sub1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    check("reset_result8", result8, 0);
    check("reset_busy8", busy8, 0);
    check("reset_done8", done8, 0);
    check("reset_result1", result1, 0);
    reset = 1'b0;
    // start is still high at reset release: nothing may start.
    idle_busy = 0;
    repeat (12) @(negedge clk) if (busy8 || busy1) idle_busy++;
    check("no_op_from_held_start", idle_busy, 0);

    run_op(0, 'h5A, 'h3C, 0, 0);
    run_op(0, 'hFF, 'h01, 0, 0);
    run_op(0, 'h00, 'h00, 0, 0);
    run_op(0, 'h10, 'h01, 1, 0);
    run_op(0, 'h01, 'h02, 1, 0);
    run_op(0, 'hFF, 'hFF, 1, 0);
    run_op(0, 'h33, 'h44, 1, 1);
    run_op(0, 'hA5, 'h5A, 0, 1);

    // Abort an operation at cnt=3 after a known prior result.
    run_op(0, 'h5A, 'h3C, 0, 0);
    @(negedge clk); start8 = 1'b0;
    @(negedge clk); a8 = 8'hC3; b8 = 8'h11; sub8 = 1'b0; start8 = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_run_busy", busy8, 1);
    check("prior_result_held", result8, 'h096);
    reset = 1'b1;
    @(negedge clk);
    check("abort_result", result8, 0);
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    reset = 1'b0;
    idle_busy = 0;
    repeat (12) @(negedge clk) if (busy8) idle_busy++;
    check("no_op_after_abort", idle_busy, 0);
    run_op(0, 'hC3, 'h11, 0, 0);

    for (int k = 0; k < 30; k++)
      run_op(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             1'($urandom), (k % 5) == 4);

    run_op(1, 1, 1, 0, 0);
    run_op(1, 0, 1, 1, 0);
    for (int k = 0; k < 6; k++)
      run_op(1, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1'($urandom), 0);

    repeat (4) @(negedge clk);
    check("q8_drained", q8.size(), 0);
    check("q1_drained", q1.size(), 0);
    check("busy_done_overlap", overlap, 0);
    check("result_changed_without_done", partial, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
